serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow-out of a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    // Pure combinational difference and borrow generation
    always_comb begin
        d  = a ^ b ^ bin;
        bo = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: accepts a, b, bin, processes one bit per clock LSB-first,
// and presents diff = a - b - bin (mod 2^WIDTH) with borrow-out under a valid/ready handshake.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-2:0]   res_r;
    logic [WIDTH-1:0]   res_nxt_s;
    logic               br_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   diff_r;
    logic               bout_r;
    logic               d_s;
    logic               bo_s;
    logic               last_s;

    full_subtractor u_fs (
        .a   (a_r[0]),
        .b   (b_r[0]),
        .bin (br_r),
        .d   (d_s),
        .bo  (bo_s)
    );

    assign last_s    = (cnt_r == LAST_CNT);
    assign res_nxt_s = {d_s, res_r};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nxt_s = SHIFT;
                else          state_nxt_s = IDLE;
            end
            SHIFT: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = SHIFT;
            end
            DONE: begin
                if (out_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand/result datapath; diff and bout only change on the final shift so they hold between operations
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            res_r  <= {(WIDTH-1){1'b0}};
            br_r   <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            diff_r <= {WIDTH{1'b0}};
            bout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        br_r  <= bin;
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    res_r <= res_nxt_s[WIDTH-1:1];
                    br_r  <= bo_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        diff_r <= res_nxt_s;
                        bout_r <= bo_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic model plus per-cycle compare and directed vectors.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit armed = 1'b0;
    logic [W-1:0] last_diff = '0;
    res_t exp_q[$];
    res_t res_log[$];
    int   acc_log[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .diff      (diff),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        res_t r;
        int   full;
        full = int'(ma) - int'(mb) - int'(mbin);
        if (full < 0) full = full + (1 << W);
        r.d = full[W-1:0];
        r.b = (int'(ma) < int'(mb) + int'(mbin));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    endtask

    // Model update on each rising edge: accepts, deliveries, reset
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            last_diff = '0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                last_diff = exp_q[0].d;
                res_log.push_back({diff, bout});
                void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, bin));
                acc_cyc = cyc;
                acc_log.push_back(cyc);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            bit busy;
            bit ov;
            busy = (exp_q.size() > 0);
            ov   = busy && ((cyc - acc_cyc) >= W);
            chk("in_ready", in_ready, !busy);
            chk("out_valid", out_valid, ov);
            if (ov) begin
                chk("diff", diff, exp_q[0].d);
                chk("bout", bout, exp_q[0].b);
            end else begin
                chk("diff_hold", diff, last_diff);
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", in_ready, 1'b1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input logic [W-1:0] ed, input logic eb, input int hold);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", out_valid, 1'b1);
        chk("diff_lit", diff, ed);
        chk("bout_lit", bout, eb);
        for (int i = 0; i < hold; i++) @(negedge clk);
        if (hold > 0) begin
            chk("ov_bp", out_valid, 1'b1);
            chk("diff_bp", diff, ed);
            chk("bout_bp", bout, eb);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int n0;
        int r0;
        int n;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        send(8'h05, 8'h03, 1'b0);
        finish_op(8'h02, 1'b0, 5);
        send(8'h00, 8'h01, 1'b0);
        finish_op(8'hFF, 1'b1, 0);
        send(8'hFF, 8'hFF, 1'b1);
        finish_op(8'hFF, 1'b1, 0);
        send(8'h80, 8'h7F, 1'b1);
        finish_op(8'h00, 1'b0, 0);

        // New operands offered during SHIFT must be ignored
        send(8'h3C, 8'h15, 1'b0);
        a = 8'hFF; b = 8'h00; bin = 1'b1; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        finish_op(8'h27, 1'b0, 0);

        // Reset on the third SHIFT cycle discards the operation
        send(8'h55, 8'h22, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_diff", diff, 8'h00);
        send(8'h10, 8'h01, 1'b0);
        finish_op(8'h0F, 1'b0, 0);

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        n0 = acc_log.size();
        r0 = res_log.size();
        a = 8'h01; b = 8'h02; bin = 1'b0; in_valid = 1'b1;
        n = 0;
        while (acc_log.size() < n0 + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        a = 8'hA0; b = 8'h0A; bin = 1'b1;
        n = 0;
        while (acc_log.size() < n0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc_log.size(), n0 + 2);
        if (acc_log.size() >= n0 + 2)
            chk("b2b_interval", acc_log[n0+1] - acc_log[n0], W + 2);
        n = 0;
        while (res_log.size() < r0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_results", res_log.size(), r0 + 2);
        if (res_log.size() >= r0 + 2) begin
            chk("b2b_first", res_log[r0], {8'hFF, 1'b1});
            chk("b2b_second", res_log[r0+1], {8'h95, 1'b0});
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
